dmem_responder: RTL and testbench

Memory-side responder for the execute-stage load/store port: accepts one read or write request per cycle, performs byte-lane alignment for every load/store width, and returns registered read data together with `rready`/`wready`. The pipeline derives its dcache stall from ready being low. The block sits where the data cache will go. It is a synthesizable, latency-configurable stand-in, so the back-end stall path can be verified before the real cache exists.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/dmem_ram.sv | 31 +++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared load/store definitions for the EX/MEM boundary.
//   mem_type_t      : 3-bit access-type encoding driven by EX
//   is_store()      : access writes memory
//   is_signed_load(): sub-word load is sign-extended
package mem_pkg;

    typedef enum logic [2:0] {
        MT_LD_W  = 3'b000,
        MT_ST_W  = 3'b001,
        MT_LD_B  = 3'b010,
        MT_LD_H  = 3'b011,
        MT_LD_BU = 3'b100,
        MT_LD_HU = 3'b101,
        MT_ST_B  = 3'b110,
        MT_ST_H  = 3'b111
    } mem_type_t;

    function automatic logic is_store(mem_type_t t);
        return (t == MT_ST_W) || (t == MT_ST_B) || (t == MT_ST_H);
    endfunction

    function automatic logic is_signed_load(mem_type_t t);
        return (t == MT_LD_B) || (t == MT_LD_H);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables.
//   clk   : write clock
//   addr  : word index (shared by read and write)
//   be    : byte-lane write enables, lane i = bits [8i+7:8i]
//   wdata : lane-aligned write data
//   rdata : asynchronous read of the addressed word (pre-write contents
//           during the write cycle, i.e. read-first)
// No reset on the array.
module dmem_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Latency-configurable data-memory responder standing in for the dcache.
// Accepts one load or store per idle cycle, aligns byte lanes, registers
// load data, and holds off the pipeline for LATENCY cycles after each access.
//   clk, rstn        : clock, async active-low reset
//   rvalid / wvalid  : load / store request from EX
//   addr             : byte address
//   mem_type         : access type (mem_pkg::mem_type_t encoding)
//   wdata            : right-aligned store data
//   rdata            : registered, extended load result
//   rready / wready  : high while idle (no combinational input path)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready high, accepting a request on any edge with a valid
// ST_WAIT | counting cnt down to 1, inputs ignored, ready low
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rvalid,
    input  logic        wvalid,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_type,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rready,
    output logic        wready
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_type_t   mt;
    logic        accept, do_write, do_read;
    logic [3:0]  be;
    logic [31:0] wdata_al;
    logic [31:0] ram_rdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic        unused_addr_hi;

    assign mt       = mem_type_t'(mem_type);
    assign accept   = (state_q == ST_IDLE) && (rvalid || wvalid);
    // Simultaneous rvalid/wvalid performs only the write.
    assign do_write = accept && wvalid;
    assign do_read  = accept && rvalid && !wvalid;

    assign rready = (state_q == ST_IDLE);
    assign wready = (state_q == ST_IDLE);

    // Address bits above the RAM depth alias onto the same words.
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (LAT != 4'd0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sub-word stores replicate the data across lanes; be picks the lane.
    always_comb begin
        be       = 4'b1111;
        wdata_al = wdata;
        case (mt)
            MT_ST_B: begin
                be       = 4'b0001 << addr[1:0];
                wdata_al = {4{wdata[7:0]}};
            end
            MT_ST_H: begin
                be       = addr[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (!do_write) begin
            be = 4'b0000;
        end
    end

    dmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .addr  (addr[ADDR_WIDTH+1:2]),
        .be    (be),
        .wdata (wdata_al),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_byte  = 8'(ram_rdata >> {addr[1:0], 3'b000});
        rd_half  = addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_val = ram_rdata;
        case (mt)
            MT_LD_B, MT_LD_BU:
                load_val = {{24{is_signed_load(mt) & rd_byte[7]}}, rd_byte};
            MT_LD_H, MT_LD_HU:
                load_val = {{16{is_signed_load(mt) & rd_half[15]}}, rd_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= 32'd0;
        end else if (do_read) begin
            rdata <= load_val;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: instance A has LATENCY 0, instance B has LATENCY 3.
// Expected values come from directed constants and a word-array model.
module tb_dmem_responder;

    localparam logic [2:0] LD_W = 3'b000, ST_W = 3'b001, LD_B = 3'b010, LD_H = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100, LD_HU = 3'b101, ST_B = 3'b110, ST_H = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rstn, a_rvalid, a_wvalid, a_rready, a_wready;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  a_mt;
    logic        b_rstn, b_rvalid, b_wvalid, b_rready, b_wready;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [2:0]  b_mt;

    int errors = 0;
    int checks = 0;
    bit [31:0] ma [int];
    bit [31:0] mb [int];

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u_a (
        .clk(clk), .rstn(a_rstn), .rvalid(a_rvalid), .wvalid(a_wvalid), .addr(a_addr),
        .mem_type(a_mt), .wdata(a_wdata), .rdata(a_rdata), .rready(a_rready), .wready(a_wready)
    );

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) u_b (
        .clk(clk), .rstn(b_rstn), .rvalid(b_rvalid), .wvalid(b_wvalid), .addr(b_addr),
        .mem_type(b_mt), .wdata(b_wdata), .rdata(b_rdata), .rready(b_rready), .wready(b_wready)
    );

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % 4096);
    endfunction

    function automatic logic [31:0] ref_merge(logic [31:0] old, logic [2:0] mt, logic [31:0] a, logic [31:0] wd);
        int sh;
        case (mt)
            ST_B: begin
                sh = 8 * int'(a % 4);
                return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end
            ST_H: begin
                sh = (a % 4 >= 2) ? 16 : 0;
                return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] word, logic [2:0] mt, logic [31:0] a);
        logic [31:0] b, h;
        b = (word >> (8 * int'(a % 4))) & 32'hFF;
        h = (word >> ((a % 4 >= 2) ? 16 : 0)) & 32'hFFFF;
        case (mt)
            LD_B:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            LD_BU:   return b;
            LD_H:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            LD_HU:   return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ma_word(logic [31:0] a);
        return ma.exists(widx(a)) ? ma[widx(a)] : 32'd0;
    endfunction

    function automatic logic [31:0] mb_word(logic [31:0] a);
        return mb.exists(widx(a)) ? mb[widx(a)] : 32'd0;
    endfunction

    // One access on instance A; returns #1 after the acceptance edge.
    task automatic a_op(input logic rd, input logic wr, input logic [2:0] mt,
                        input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        a_rvalid = rd; a_wvalid = wr; a_mt = mt; a_addr = ad; a_wdata = wd;
        @(posedge clk); #1;
        a_rvalid = 1'b0; a_wvalid = 1'b0;
        if (wr) ma[widx(ad)] = ref_merge(ma_word(ad), mt, ad, wd);
    endtask

    // One access on instance B, called while B is ready and between edges.
    // mode 0: idle inputs during the wait; 1: random noise; 2: keep request held.
    task automatic b_issue(input logic rd, input logic wr, input logic [2:0] mt,
                           input logic [31:0] ad, input logic [31:0] wd, input int mode,
                           output int low, output time t_acc);
        b_rvalid = rd; b_wvalid = wr; b_mt = mt; b_addr = ad; b_wdata = wd;
        if (wr) mb[widx(ad)] = ref_merge(mb_word(ad), mt, ad, wd);
        @(posedge clk); #1;
        t_acc = $time;
        low = 0;
        if (mode != 2) begin
            b_rvalid = 1'b0; b_wvalid = 1'b0;
        end
        while (b_rready !== 1'b1 && low < 20) begin
            low++;
            if (mode == 1) begin
                b_rvalid = 1'($urandom);
                b_wvalid = 1'($urandom);
                b_mt     = 3'($urandom);
                b_addr   = 32'($urandom_range(32'h20, 32'h2F));
                b_wdata  = $urandom;
            end
            @(posedge clk); #1;
        end
        if (mode != 2) begin
            b_rvalid = 1'b0; b_wvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        a_rstn = 1'b0; b_rstn = 1'b0;
        a_rvalid = 1'b0; a_wvalid = 1'b0; a_mt = LD_W; a_addr = '0; a_wdata = '0;
        b_rvalid = 1'b0; b_wvalid = 1'b0; b_mt = LD_W; b_addr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        if (a_rdata !== 32'd0) begin errors++; $display("FAIL reset_a_rdata: got %h expected 00000000", a_rdata); end
        checks++;
        if (a_rready !== 1'b1 || a_wready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got r=%b w=%b expected 1", a_rready, a_wready); end
        checks++;
        if (b_rdata !== 32'd0) begin errors++; $display("FAIL reset_b_rdata: got %h expected 00000000", b_rdata); end
        checks++;
        if (b_rready !== 1'b1 || b_wready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got r=%b w=%b expected 1", b_rready, b_wready); end
        checks++;
        @(negedge clk);
        a_rstn = 1'b1; b_rstn = 1'b1;
        @(posedge clk); #1;
        if (a_rready !== 1'b1 || b_rready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got a=%b b=%b expected 1", a_rready, b_rready); end
        checks++;
    endtask

    task automatic test_align_a();
        logic [31:0] ta [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [2:0]  tm [4] = '{LD_B, LD_BU, LD_H, LD_HU};
        logic [31:0] te [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        a_op(1'b0, 1'b1, ST_W, 32'h10, 32'hDEADBEEF);
        a_op(1'b1, 1'b0, LD_W, 32'h10, 32'h0);
        if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ldw_basic: got %h expected deadbeef", a_rdata); end
        checks++;
        if (a_rready !== 1'b1 || a_wready !== 1'b1) begin errors++; $display("FAIL lat0_ready: got r=%b w=%b expected 1", a_rready, a_wready); end
        checks++;
        for (int i = 0; i < 4; i++) begin
            a_op(1'b1, 1'b0, tm[i], ta[i], 32'h0);
            if (a_rdata !== te[i]) begin errors++; $display("FAIL subword_load %0d: got %h expected %h", i, a_rdata, te[i]); end
            checks++;
        end
        a_op(1'b0, 1'b1, ST_B, 32'h11, 32'hFFFFFF55);
        if (a_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL rdata_hold_store: got %h expected 0000beef", a_rdata); end
        checks++;
        a_op(1'b0, 1'b1, ST_H, 32'h12, 32'hFFFF1234);
        a_op(1'b1, 1'b0, LD_W, 32'h10, 32'h0);
        if (a_rdata !== 32'h123455EF) begin errors++; $display("FAIL subword_store: got %h expected 123455ef", a_rdata); end
        checks++;
    endtask

    task automatic test_wrap_a();
        a_op(1'b0, 1'b1, ST_W, 32'h4000, 32'hA5A5A5A5);
        a_op(1'b1, 1'b0, LD_W, 32'h0, 32'h0);
        if (a_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL addr_wrap: got %h expected a5a5a5a5", a_rdata); end
        checks++;
    endtask

    task automatic test_simultaneous_a();
        a_op(1'b1, 1'b0, LD_W, 32'h10, 32'h0);
        a_op(1'b1, 1'b1, ST_W, 32'h18, 32'h0BADF00D);
        if (a_rdata !== 32'h123455EF) begin errors++; $display("FAIL rw_both_rdata: got %h expected 123455ef", a_rdata); end
        checks++;
        repeat (3) @(posedge clk);
        #1;
        if (a_rdata !== 32'h123455EF) begin errors++; $display("FAIL rdata_hold_idle: got %h expected 123455ef", a_rdata); end
        checks++;
        a_op(1'b1, 1'b0, LD_W, 32'h18, 32'h0);
        if (a_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rw_both_write: got %h expected 0badf00d", a_rdata); end
        checks++;
    endtask

    task automatic test_back_to_back_a();
        logic [2:0]  st_t [3] = '{ST_W, ST_B, ST_H};
        logic [2:0]  ld_t [5] = '{LD_W, LD_B, LD_H, LD_BU, LD_HU};
        logic [31:0] exp_rd, ad, wd;
        logic [2:0]  mt;
        logic        wr;
        for (int w = 0; w < 16; w++) a_op(1'b0, 1'b1, ST_W, 32'(w * 4), $urandom);
        exp_rd = '0;
        for (int i = 0; i < 300; i++) begin
            wr = (i == 0) ? 1'b0 : 1'($urandom);
            mt = wr ? st_t[$urandom_range(0, 2)] : ld_t[$urandom_range(0, 4)];
            ad = 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 14);
            wd = $urandom;
            @(negedge clk);
            a_rvalid = !wr; a_wvalid = wr; a_mt = mt; a_addr = ad; a_wdata = wd;
            if (wr) ma[widx(ad)] = ref_merge(ma_word(ad), mt, ad, wd);
            else    exp_rd = ref_load(ma_word(ad), mt, ad);
            @(posedge clk); #1;
            if (a_rready !== 1'b1 || a_wready !== 1'b1) begin errors++; $display("FAIL b2b_ready %0d: got r=%b w=%b expected 1", i, a_rready, a_wready); end
            checks++;
            if (a_rdata !== exp_rd) begin errors++; $display("FAIL b2b_rdata %0d: type %0d addr %h got %h expected %h", i, mt, ad, a_rdata, exp_rd); end
            checks++;
        end
        a_rvalid = 1'b0; a_wvalid = 1'b0;
    endtask

    task automatic test_latency_b();
        int low;
        time t1, t2;
        logic [31:0] v, w;
        v = $urandom;
        w = $urandom;
        b_issue(1'b0, 1'b1, ST_W, 32'h20, v, 0, low, t1);
        if (low != 3) begin errors++; $display("FAIL lat3_store_stall: got %0d expected 3", low); end
        checks++;
        b_issue(1'b1, 1'b0, LD_W, 32'h20, 32'h0, 2, low, t1);
        if (low != 3) begin errors++; $display("FAIL lat3_load_stall: got %0d expected 3", low); end
        checks++;
        if (b_rdata !== v) begin errors++; $display("FAIL lat3_load_data: got %h expected %h", b_rdata, v); end
        checks++;
        b_issue(1'b1, 1'b0, LD_W, 32'h20, 32'h0, 2, low, t2);
        b_rvalid = 1'b0; b_wvalid = 1'b0;
        if (t2 - t1 != 40) begin errors++; $display("FAIL lat3_held_accept: got %0t expected 40 between accepts", t2 - t1); end
        checks++;
        if (low != 3 || b_rdata !== v) begin errors++; $display("FAIL lat3_second: got stall %0d data %h expected 3 %h", low, b_rdata, v); end
        checks++;
        b_issue(1'b0, 1'b1, ST_W, 32'h24, w, 0, low, t1);
        b_issue(1'b1, 1'b0, LD_H, 32'h26, 32'h0, 1, low, t1);
        if (low != 3) begin errors++; $display("FAIL lat3_noise_stall: got %0d expected 3", low); end
        checks++;
        if (b_rdata !== ref_load(w, LD_H, 32'h26)) begin errors++; $display("FAIL lat3_noise_rdata: got %h expected %h", b_rdata, ref_load(w, LD_H, 32'h26)); end
        checks++;
        b_issue(1'b1, 1'b0, LD_W, 32'h20, 32'h0, 0, low, t1);
        if (b_rdata !== mb_word(32'h20)) begin errors++; $display("FAIL lat3_noise_mem20: got %h expected %h", b_rdata, mb_word(32'h20)); end
        checks++;
        b_issue(1'b1, 1'b0, LD_W, 32'h24, 32'h0, 0, low, t1);
        if (b_rdata !== mb_word(32'h24)) begin errors++; $display("FAIL lat3_noise_mem24: got %h expected %h", b_rdata, mb_word(32'h24)); end
        checks++;
    endtask

    task automatic test_reset_mid_wait_b();
        int low;
        time t;
        logic [31:0] y, z;
        y = $urandom;
        z = $urandom | 32'h1;
        b_issue(1'b0, 1'b1, ST_W, 32'h30, y, 0, low, t);
        b_issue(1'b1, 1'b0, LD_W, 32'h30, 32'h0, 0, low, t);
        b_rvalid = 1'b0; b_wvalid = 1'b1; b_mt = ST_W; b_addr = 32'h34; b_wdata = z;
        mb[widx(32'h34)] = z;
        @(posedge clk); #1;
        b_wvalid = 1'b0;
        if (b_rready !== 1'b0) begin errors++; $display("FAIL mid_wait_busy: got %b expected 0", b_rready); end
        checks++;
        @(posedge clk); #1;
        b_rstn = 1'b0;
        #1;
        if (b_rready !== 1'b1 || b_wready !== 1'b1) begin errors++; $display("FAIL mid_wait_reset_ready: got r=%b w=%b expected 1", b_rready, b_wready); end
        checks++;
        if (b_rdata !== 32'd0) begin errors++; $display("FAIL mid_wait_reset_rdata: got %h expected 00000000", b_rdata); end
        checks++;
        #2;
        b_rstn = 1'b1;
        @(posedge clk); #1;
        if (b_rready !== 1'b1) begin errors++; $display("FAIL mid_wait_aborted: got %b expected 1", b_rready); end
        checks++;
        b_issue(1'b1, 1'b0, LD_W, 32'h34, 32'h0, 0, low, t);
        if (b_rdata !== z || low != 3) begin errors++; $display("FAIL store_persists: got %h stall %0d expected %h 3", b_rdata, low, z); end
        checks++;
        b_issue(1'b1, 1'b0, LD_W, 32'h30, 32'h0, 0, low, t);
        if (b_rdata !== y) begin errors++; $display("FAIL earlier_store_persists: got %h expected %h", b_rdata, y); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_align_a();
        test_wrap_a();
        test_simultaneous_a();
        test_back_to_back_a();
        test_latency_b();
        test_reset_mid_wait_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
